// File: rtl/axis_integrator.sv
// Streaming running-sum integrator with a registered 2-entry (output + skid) buffer.
// Optional signed saturation and sat_flag port when AXIS_INTEGRATOR_SATURATE_EN is defined.
module axis_integrator #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        clear,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
`ifdef AXIS_INTEGRATOR_SATURATE_EN
  output logic                        sat_flag,
`endif
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready
);
  localparam int W = AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t         r_state;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_or;
  logic [W-1:0]   r_sk;
  logic           r_tready;

  state_t         w_next_state;
  logic           w_in_xfer;
  logic           w_out_xfer;
  logic [W-1:0]   w_base;
  logic [W-1:0]   w_sum;

  assign w_in_xfer  = S_AXIS_tvalid & r_tready;
  assign w_out_xfer = (r_state != ST_EMPTY) & M_AXIS_tready;
  assign w_base     = clear ? '0 : r_acc;

`ifdef AXIS_INTEGRATOR_SATURATE_EN
  logic [W:0] w_wide;
  logic       w_ovf;
  logic       r_sat;

  // One extra bit exposes signed overflow: the top two bits disagree.
  assign w_wide = {w_base[W-1], w_base} + {S_AXIS_tdata[W-1], S_AXIS_tdata};
  assign w_ovf  = w_wide[W] ^ w_wide[W-1];
  assign w_sum  = !w_ovf     ? w_wide[W-1:0] :
                  w_wide[W]  ? {1'b1, {(W-1){1'b0}}} :
                               {1'b0, {(W-1){1'b1}}};
  assign sat_flag = r_sat;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_sat <= 1'b0;
    else        r_sat <= w_in_xfer & w_ovf;
  end
`else
  assign w_sum = w_base + S_AXIS_tdata;
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: if (w_in_xfer) w_next_state = ST_ONE;
      ST_ONE: begin
        if (w_in_xfer && !w_out_xfer)      w_next_state = ST_FULL;
        else if (!w_in_xfer && w_out_xfer) w_next_state = ST_EMPTY;
      end
      ST_FULL:  if (w_out_xfer) w_next_state = ST_ONE;
      default:  w_next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_EMPTY;
      r_acc    <= '0;
      r_or     <= '0;
      r_sk     <= '0;
      r_tready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_next_state;
      r_tready <= (w_next_state != ST_FULL);

      if (w_in_xfer)  r_acc <= w_sum;
      else if (clear) r_acc <= '0;

      case (r_state)
        ST_EMPTY: if (w_in_xfer) r_or <= w_sum;
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) r_or <= w_sum;
          else if (w_in_xfer)          r_sk <= w_sum;
        end
        ST_FULL:  if (w_out_xfer) r_or <= r_sk;
        default: ;
      endcase
    end
  end

  assign S_AXIS_tready = r_tready;
  assign M_AXIS_tvalid = (r_state != ST_EMPTY);
  assign M_AXIS_tdata  = r_or;

endmodule

// File: tb/tb_axis_integrator.sv
// Scoreboard bench for axis_integrator: driver pushes hand-computed sums, a negedge monitor pops on each output handshake.
module tb_axis_integrator;
  localparam int W = 32;

  logic         aclk = 1'b0;
  logic         areset;
  logic         clear;
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
`ifdef AXIS_INTEGRATOR_SATURATE_EN
  logic         sat_flag;
`endif

  axis_integrator #(.AXIS_TDATA_WIDTH(W)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .clear         (clear),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
`ifdef AXIS_INTEGRATOR_SATURATE_EN
    .sat_flag      (sat_flag),
`endif
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [W-1:0] data, input logic clr, input logic [W-1:0] exp);
    logic rdy;
    int   waited;
    s_tdata  = data;
    s_tvalid = 1'b1;
    clear    = clr;
    waited   = 0;
    forever begin
      @(negedge aclk);
      rdy = s_tready;
      @(posedge aclk);
      if (rdy) begin
        exp_q.push_back(exp);
        break;
      end
      waited++;
      if (waited > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: data 0x%08h never accepted", data);
        break;
      end
    end
    #1;
    s_tvalid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge aclk);
    #1;
    clear = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge aclk);
    #1;
    check(name, W'(exp_q.size()), '0);
  endtask

  // Monitor: a handshake visible at negedge completes at the next posedge.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%08h, expected no output", m_tdata);
      end else begin
        check("output_data", m_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    areset   = 1'b1;
    clear    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    #2;
    check("reset_tvalid", W'(m_tvalid), '0);
    check("reset_tdata",  m_tdata,      '0);
    check("reset_tready", W'(s_tready), '0);
    #6 areset = 1'b0;
    @(posedge aclk);
    #1;
    check("tready_after_reset", W'(s_tready), 1);

    // Streaming: 5, -2, 10, 0 -> 5, 3, 13, 13
    send(32'd5, 1'b0, 32'd5);
    check("first_out_latency", W'(m_tvalid), 1);
    send(32'hFFFF_FFFE, 1'b0, 32'd3);
    send(32'd10, 1'b0, 32'd13);
    send(32'd0, 1'b0, 32'd13);
    @(negedge aclk);
    #1;
    check("stream_rate", W'(exp_q.size()), '0);
    drain("stream_drain");

    // Backpressure: 1, 2 fill the buffer, 3 waits until ready rises
    clear_pulse();
    m_tready = 1'b0;
    send(32'd1, 1'b0, 32'd1);
    send(32'd2, 1'b0, 32'd3);
    check("bp_tready_low", W'(s_tready), '0);
    fork
      send(32'd3, 1'b0, 32'd6);
      begin
        repeat (3) @(posedge aclk);
        #1;
        check("bp_hold_tdata", m_tdata, 32'd1);
        check("bp_hold_tvalid", W'(m_tvalid), 1);
        m_tready = 1'b1;
      end
    join
    drain("bp_drain");

    // Clear behaviour
    clear_pulse();
    send(32'd4, 1'b0, 32'd4);
    send(32'd4, 1'b0, 32'd8);
    send(32'd7, 1'b1, 32'd7);
    clear_pulse();
    send(32'd1, 1'b0, 32'd1);
    drain("clear_drain");

`ifdef AXIS_INTEGRATOR_SATURATE_EN
    clear_pulse();
    send(32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF);
    check("sat_flag_idle", W'(sat_flag), '0);
    send(32'd1, 1'b0, 32'h7FFF_FFFF);
    check("sat_flag_pos", W'(sat_flag), 1);
    send(32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFE);
    check("sat_flag_drop", W'(sat_flag), '0);
    clear_pulse();
    send(32'h8000_0000, 1'b0, 32'h8000_0000);
    send(32'hFFFF_FFFF, 1'b0, 32'h8000_0000);
    check("sat_flag_neg", W'(sat_flag), 1);
    drain("sat_drain");
`else
    clear_pulse();
    send(32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF);
    send(32'd1, 1'b0, 32'h8000_0000);
    drain("wrap_drain");
`endif

    // Reset mid-stream while FULL
    m_tready = 1'b0;
    send(32'd20, 1'b0, 32'd0);
    send(32'd30, 1'b0, 32'd0);
    check("full_tready_low", W'(s_tready), '0);
    #3 areset = 1'b1;
    #1;
    check("midreset_tvalid", W'(m_tvalid), '0);
    check("midreset_tdata",  m_tdata,      '0);
    exp_q.delete();
    @(negedge aclk);
    areset   = 1'b0;
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    send(32'd9, 1'b0, 32'd9);
    drain("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
